// File: rtl/mem_line_adapter.sv
// Line-to-word adapter: turns one multi-word line request into a burst of
// single-word SRAM accesses, with an idle-time preload port for the SRAM.
module mem_line_adapter #(
   parameter int LINE_WORDS = 4,
   parameter int WORD_W     = 32,
   parameter int ADDR_W     = 20,
   parameter int SRAM_AW    = 6,
   parameter int SRAM_LAT   = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic                         req_we,
   input  logic [ADDR_W-1:0]            req_addr,
   input  logic [LINE_WORDS*WORD_W-1:0] req_wdata,
   input  logic                         abort,
   output logic                         resp_valid,
   output logic [LINE_WORDS*WORD_W-1:0] resp_rdata,
   input  logic                         load_en,
   input  logic [ADDR_W-1:0]            load_addr,
   input  logic [WORD_W-1:0]            load_data,
   output logic                         sram_csb,
   output logic                         sram_web,
   output logic [SRAM_AW-1:0]           sram_addr,
   output logic [WORD_W-1:0]            sram_din,
   input  logic [WORD_W-1:0]            sram_dout
);

   localparam int CW = $clog2(LINE_WORDS + SRAM_LAT) + 1;
   localparam int IW = $clog2(LINE_WORDS);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WRITE = 2'd1;
   localparam logic [1:0] READ  = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   logic [1:0]                          state;
   logic [CW-1:0]                       k;
   logic [SRAM_AW-1:0]                  addr_q;
   logic [LINE_WORDS-1:0][WORD_W-1:0]   wdata_q;
   logic [LINE_WORDS-1:0][WORD_W-1:0]   shadow;
   logic [LINE_WORDS-1:0][WORD_W-1:0]   next_line;
   logic [CW-1:0]                       cap_idx;
   logic                                accept;
   logic                                issuing;
   logic                                load_active;
   logic                                capture;
   logic                                last_cap;
   logic                                unused_bits;

   assign req_ready   = (state == IDLE) && !load_en && !abort;
   assign accept      = req_valid && req_ready;
   assign issuing     = (state == WRITE) || (state == READ);
   assign load_active = (state == IDLE) && load_en && !reset;

   // Read data for word k arrives SRAM_LAT cycles after it was issued, so the
   // word captured in counter cycle k is word k-SRAM_LAT.
   assign cap_idx  = k - CW'(SRAM_LAT);
   assign capture  = ((state == READ) || (state == DRAIN)) && (k >= CW'(SRAM_LAT));
   assign last_cap = capture && (cap_idx == CW'(LINE_WORDS - 1));

   assign unused_bits = ^{req_addr[ADDR_W-1:SRAM_AW], load_addr[ADDR_W-1:SRAM_AW],
                          cap_idx[CW-1:IW]};

   always_comb begin
      next_line = shadow;
      if (capture)
         next_line[cap_idx[IW-1:0]] = sram_dout;
   end

   always_comb begin
      sram_csb  = 1'b1;
      sram_web  = 1'b1;
      sram_addr = '0;
      sram_din  = '0;
      if (issuing && !reset) begin
         sram_csb  = 1'b0;
         sram_web  = (state == READ);
         sram_addr = addr_q + SRAM_AW'(k);
         sram_din  = (state == WRITE) ? wdata_q[k[IW-1:0]] : '0;
      end else if (load_active) begin
         sram_csb  = 1'b0;
         sram_web  = 1'b0;
         sram_addr = load_addr[SRAM_AW-1:0];
         sram_din  = load_data;
      end
   end

   // Abort wins over completion, so a cancelled line never produces a response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         k          <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         shadow     <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
      end else begin
         resp_valid <= 1'b0;
         if (capture)
            shadow <= next_line;
         case (state)
            IDLE: begin
               if (accept) begin
                  addr_q  <= req_addr[SRAM_AW-1:0];
                  wdata_q <= req_wdata;
                  k       <= '0;
                  state   <= req_we ? WRITE : READ;
               end
            end
            WRITE: begin
               if (abort) begin
                  state <= IDLE;
                  k     <= '0;
               end else if (k == CW'(LINE_WORDS - 1)) begin
                  state      <= IDLE;
                  k          <= '0;
                  resp_valid <= 1'b1;
               end else begin
                  k <= k + CW'(1);
               end
            end
            READ: begin
               if (abort) begin
                  state <= IDLE;
                  k     <= '0;
               end else begin
                  k <= k + CW'(1);
                  if (k == CW'(LINE_WORDS - 1))
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               if (abort) begin
                  state <= IDLE;
                  k     <= '0;
               end else if (last_cap) begin
                  state      <= IDLE;
                  k          <= '0;
                  resp_valid <= 1'b1;
                  resp_rdata <= next_line;
               end else begin
                  k <= k + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               k     <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_line_adapter.sv
// Directed bench for mem_line_adapter with a behavioural one-cycle-latency SRAM.
module tb_mem_line_adapter;

   logic         clk = 1'b0;
   logic         reset;
   logic         req_valid;
   logic         req_ready;
   logic         req_we;
   logic [19:0]  req_addr;
   logic [127:0] req_wdata;
   logic         abort;
   logic         resp_valid;
   logic [127:0] resp_rdata;
   logic         load_en;
   logic [19:0]  load_addr;
   logic [31:0]  load_data;
   logic         sram_csb;
   logic         sram_web;
   logic [5:0]   sram_addr;
   logic [31:0]  sram_din;
   logic [31:0]  sram_dout;

   logic [31:0]  mem [64];
   logic [5:0]   addr_seq [4];

   int tests_run = 0;
   int tests_failed = 0;

   mem_line_adapter dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .abort      (abort),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .load_en    (load_en),
      .load_addr  (load_addr),
      .load_data  (load_data),
      .sram_csb   (sram_csb),
      .sram_web   (sram_web),
      .sram_addr  (sram_addr),
      .sram_din   (sram_din),
      .sram_dout  (sram_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!sram_csb) begin
         if (!sram_web)
            mem[sram_addr] <= sram_din;
         else
            sram_dout <= mem[sram_addr];
      end
   end

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one line request and watches up to 12 cycles after the accept edge.
   task automatic applyStimulus(input logic we, input logic [19:0] addr, input logic [127:0] wdata,
                                output int lat, output int npulse, output logic [127:0] rdata,
                                output logic ready_low);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      @(negedge clk);
      checkOutput("accept_ready", 128'(req_ready), 128'd1);
      tick();
      req_valid = 1'b0;
      lat       = -1;
      npulse    = 0;
      rdata     = '0;
      ready_low = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c < 4)
            addr_seq[c] = sram_addr;
         if (resp_valid) begin
            npulse++;
            if (lat < 0) begin
               lat   = c;
               rdata = resp_rdata;
            end
         end
         if (lat < 0 && req_ready)
            ready_low = 1'b0;
         tick();
      end
   endtask

   initial begin
      int           lat;
      int           npulse;
      logic [127:0] rdata;
      logic [127:0] prior;
      logic         ready_low;
      logic         seen;

      for (int i = 0; i < 64; i++)
         mem[i] = '0;
      sram_dout = '0;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      abort     = 1'b0;
      load_en   = 1'b0;
      load_addr = '0;
      load_data = '0;
      tick();
      tick();
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_ready", 128'(req_ready), 128'd1);
      checkOutput("rst_resp_valid", 128'(resp_valid), 128'd0);
      checkOutput("rst_rdata", resp_rdata, 128'd0);
      checkOutput("rst_csb_web", 128'({sram_csb, sram_web}), 128'h3);
      tick();

      for (int i = 0; i < 4; i++) begin
         load_en   = 1'b1;
         load_addr = 20'(i);
         load_data = 32'(8'h11 * (i + 1));
         @(negedge clk);
         checkOutput("load_port", 128'({sram_csb, sram_web, sram_addr}), 128'(i));
         checkOutput("load_ready", 128'(req_ready), 128'd0);
         tick();
      end
      load_en = 1'b0;

      applyStimulus(1'b0, 20'd0, '0, lat, npulse, rdata, ready_low);
      checkOutput("rd0_latency", 128'(lat), 128'd5);
      checkOutput("rd0_data", rdata, 128'h00000044_00000033_00000022_00000011);
      checkOutput("rd0_pulses", 128'(npulse), 128'd1);
      checkOutput("rd0_ready_low", 128'(ready_low), 128'd1);
      checkOutput("rd0_addrs", 128'({addr_seq[0], addr_seq[1], addr_seq[2], addr_seq[3]}),
                  128'({6'd0, 6'd1, 6'd2, 6'd3}));

      applyStimulus(1'b1, 20'd8, 128'h000000A3_000000A2_000000A1_000000A0, lat, npulse, rdata, ready_low);
      checkOutput("wr8_latency", 128'(lat), 128'd4);
      checkOutput("wr8_pulses", 128'(npulse), 128'd1);
      checkOutput("wr8_ready_low", 128'(ready_low), 128'd1);
      checkOutput("wr8_rdata_held", resp_rdata, 128'h00000044_00000033_00000022_00000011);
      checkOutput("wr8_mem", 128'({mem[8], mem[9], mem[10], mem[11]}),
                  128'h000000A0_000000A1_000000A2_000000A3);

      applyStimulus(1'b0, 20'd8, '0, lat, npulse, rdata, ready_low);
      checkOutput("rd8_latency", 128'(lat), 128'd5);
      checkOutput("rd8_data", rdata, 128'h000000A3_000000A2_000000A1_000000A0);
      checkOutput("rd8_ready_low", 128'(ready_low), 128'd1);

      applyStimulus(1'b0, 20'd62, '0, lat, npulse, rdata, ready_low);
      checkOutput("rd62_addrs", 128'({addr_seq[0], addr_seq[1], addr_seq[2], addr_seq[3]}),
                  128'({6'd62, 6'd63, 6'd0, 6'd1}));
      checkOutput("rd62_data", rdata, 128'h00000022_00000011_00000000_00000000);
      prior = resp_rdata;

      // Abort during cycle 2 of a read.
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 20'd0;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      abort = 1'b1;
      @(negedge clk);
      checkOutput("abort_ready_low", 128'(req_ready), 128'd0);
      tick();
      abort = 1'b0;
      @(negedge clk);
      checkOutput("abort_idle_ready", 128'(req_ready), 128'd1);
      checkOutput("abort_idle_csb", 128'(sram_csb), 128'd1);
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (resp_valid)
            seen = 1'b1;
      end
      checkOutput("abort_no_resp", 128'(seen), 128'd0);
      checkOutput("abort_rdata_held", resp_rdata, prior);
      tick();

      // Abort together with a request in IDLE must not accept it.
      req_valid = 1'b1;
      abort     = 1'b1;
      @(negedge clk);
      checkOutput("abort_idle_no_ready", 128'(req_ready), 128'd0);
      tick();
      req_valid = 1'b0;
      abort     = 1'b0;
      @(negedge clk);
      checkOutput("abort_idle_not_taken", 128'(sram_csb), 128'd1);
      tick();

      // Preload and request in the same cycle: the preload wins.
      load_en   = 1'b1;
      load_addr = 20'd5;
      load_data = 32'h55;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 20'd4;
      @(negedge clk);
      checkOutput("clash_ready", 128'(req_ready), 128'd0);
      checkOutput("clash_port", 128'({sram_csb, sram_web, sram_addr, sram_din}),
                  128'({1'b0, 1'b0, 6'd5, 32'h55}));
      tick();
      load_en   = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("clash_not_taken", 128'({sram_csb, req_ready}), 128'({1'b1, 1'b1}));
      tick();
      applyStimulus(1'b0, 20'd4, '0, lat, npulse, rdata, ready_low);
      checkOutput("clash_read_data", rdata, 128'h00000000_00000000_00000055_00000000);

      // Reset in the middle of a write.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 20'd16;
      req_wdata = 128'h000000B3_000000B2_000000B1_000000B0;
      tick();
      req_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      checkOutput("midrst_outputs", 128'({resp_valid, sram_csb, sram_web}), 128'({1'b0, 1'b1, 1'b1}));
      checkOutput("midrst_rdata", resp_rdata, 128'd0);
      checkOutput("midrst_ready", 128'(req_ready), 128'd1);
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (resp_valid || !sram_csb)
            seen = 1'b1;
      end
      checkOutput("midrst_quiet", 128'(seen), 128'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
